ps2_rx_fifo: RTL and testbench



---
 rtl/ps2_pkg.sv | 12 +
 rtl/ps2_input_filter.sv | 37 +++
 rtl/ps2_rx_fifo.sv | 138 +++++++++++++
 tb/tb_ps2_rx_fifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int   PS2_DATA_BITS  = 8;
  localparam logic PS2_IDLE_LEVEL = 1'b1;

  // Odd parity: data byte plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction
endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter on one PS/2 line.
module ps2_input_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronised samples that disagree with filt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= PS2_IDLE_LEVEL;
      s2   <= PS2_IDLE_LEVEL;
      filt <= PS2_IDLE_LEVEL;
      cnt  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filtered inputs, frame FSM with parity/stop/timeout
// checks, show-ahead receive FIFO and sticky error flags with interrupt.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            rd_en,
  input  logic                            int_clear,
  output logic [7:0]                      data,
  output logic                            valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            irq,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_f, dat_f, clk_q, fall;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst_n(rst_n), .raw(ps2_clk), .filt(clk_f));
  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(clk), .rst_n(rst_n), .raw(ps2_data), .filt(dat_f));

  assign fall = clk_q & ~clk_f;

  state_t          state, nstate;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TW-1:0]   tcnt;
  logic            timeout, push, perr_set, ferr_set;

  assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    nstate   = state;
    push     = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    if (timeout) begin
      nstate   = IDLE;
      ferr_set = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:   if (!dat_f) nstate = DATA;
        DATA:   if (bit_cnt == 3'(PS2_DATA_BITS - 1)) nstate = PARITY;
        PARITY: nstate = STOP;
        STOP: begin
          nstate = IDLE;
          // Parity is judged before the stop bit.
          if (!odd_parity_ok(shreg, par_bit)) perr_set = 1'b1;
          else if (dat_f)                     push     = 1'b1;
          else                                ferr_set = 1'b1;
        end
        default: nstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_q   <= PS2_IDLE_LEVEL;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      state <= nstate;
      clk_q <= clk_f;
      if (fall) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shreg   <= {dat_f, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  par_bit <= dat_f;
          default: ;
        endcase
      end
      if (state == IDLE || fall || timeout) tcnt <= '0;
      else                                  tcnt <= tcnt + 1'b1;
    end
  end

  // Receive FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pop, full, do_push, ovf_set;

  assign valid   = (count != '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rd_en & valid;
  assign do_push = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign data    = valid ? mem[rptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      irq        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Set events win over a coincident clear.
      parity_err <= perr_set | (parity_err & ~int_clear);
      frame_err  <= ferr_set | (frame_err & ~int_clear);
      overflow   <= ovf_set  | (overflow & ~int_clear);
      irq        <= do_push | perr_set | ferr_set | ovf_set | (irq & ~int_clear);
    end
  end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: frame-level reference model (byte queue + flags) driven by PS/2 waveforms.
module tb_ps2_rx_fifo;
  localparam int FL    = 4;
  localparam int DEPTH = 8;
  localparam int TO    = 20000;
  localparam int HALF  = 20;

  logic       clk = 0, rst_n = 0, ps2_clk = 1, ps2_data = 1, rd_en = 0, int_clear = 0;
  logic [7:0] data;
  logic       valid, irq, parity_err, frame_err, overflow;
  logic [3:0] count;

  ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .int_clear(int_clear), .data(data), .valid(valid), .count(count),
    .irq(irq), .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  // Reference model
  logic [7:0] q[$];
  logic m_perr = 0, m_ferr = 0, m_ovf = 0, m_irq = 0;

  function automatic logic good_par(input logic [7:0] b);
    return ($countones(b) % 2 == 0);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input bit glitch, input bit pop_at_fall);
    if (glitch) begin
      ps2_clk = 0; cyc(FL - 1); ps2_clk = 1; cyc(FL + 4);
    end
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 0;
    if (pop_at_fall) begin
      // strobe lands 2 sync + FL filter cycles after the pin edge
      cyc(2 + FL); rd_en = 1; cyc(1); rd_en = 0; cyc(HALF - 3 - FL);
    end else cyc(HALF);
    ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                            input bit pop_on_push, input bit glitch);
    bit popped, was_full;
    drive_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], glitch, 1'b0);
    drive_bit(p, 1'b0, 1'b0);
    popped   = pop_on_push && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    drive_bit(s, 1'b0, pop_on_push);
    cyc(4);
    if (popped) void'(q.pop_front());
    if ($countones({b, p}) % 2 == 0) begin m_perr = 1; m_irq = 1; end
    else if (!s)                     begin m_ferr = 1; m_irq = 1; end
    else if (was_full && !popped)    begin m_ovf = 1;  m_irq = 1; end
    else begin q.push_back(b); m_irq = 1; end
  endtask

  task automatic do_pop();
    rd_en = 1; cyc(1); rd_en = 0; cyc(1);
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic do_clear();
    int_clear = 1; cyc(1); int_clear = 0; cyc(1);
    m_perr = 0; m_ferr = 0; m_ovf = 0; m_irq = 0;
  endtask

  function automatic logic [7:0] m_head();
    return (q.size() > 0) ? q[0] : 8'h00;
  endfunction

  task automatic test_reset();
    rst_n = 0; cyc(3);
    n_checks++; if ({data, valid, count} !== 13'h0) $display("FAIL reset_fifo got %h exp 0", {data, valid, count}); else n_pass++;
    n_checks++; if ({irq, parity_err, frame_err, overflow} !== 4'h0) $display("FAIL reset_flags got %b exp 0000", {irq, parity_err, frame_err, overflow}); else n_pass++;
    rst_n = 1; cyc(3);
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0, 1'b1, 0, 0);
    n_checks++; if ({valid, data, count} !== {1'b1, 8'h1C, 4'd1}) $display("FAIL single_rx got %b/%h/%0d exp 1/1c/1", valid, data, count); else n_pass++;
    n_checks++; if (irq !== 1'b1) $display("FAIL single_irq got %b exp 1", irq); else n_pass++;
    do_pop();
    n_checks++; if ({valid, count, data} !== 13'h0) $display("FAIL single_pop got %b/%0d/%h exp 0/0/00", valid, count, data); else n_pass++;
    do_clear();
    n_checks++; if (irq !== 1'b0) $display("FAIL single_clear got %b exp 0", irq); else n_pass++;
  endtask

  task automatic test_back_to_back();
    send_frame(8'hF0, good_par(8'hF0), 1'b1, 0, 0);
    send_frame(8'h1C, good_par(8'h1C), 1'b1, 0, 0);
    n_checks++; if ({count, data} !== {4'd2, 8'hF0}) $display("FAIL b2b_two got %0d/%h exp 2/f0", count, data); else n_pass++;
    do_pop();
    n_checks++; if (data !== 8'h1C) $display("FAIL b2b_pop1 got %h exp 1c", data); else n_pass++;
    do_pop();
    n_checks++; if (valid !== 1'b0) $display("FAIL b2b_pop2 got %b exp 0", valid); else n_pass++;
    do_pop();
    n_checks++; if (count !== 4'd0) $display("FAIL b2b_empty_pop got %0d exp 0", count); else n_pass++;
    do_clear();
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1'b1, 1'b1, 0, 0);
    n_checks++; if ({count, parity_err, irq, frame_err} !== {4'd0, 3'b110}) $display("FAIL par_bad got cnt=%0d perr=%b irq=%b ferr=%b exp 0/1/1/0", count, parity_err, irq, frame_err); else n_pass++;
    send_frame(8'h32, 1'b0, 1'b1, 0, 0);
    n_checks++; if ({data, parity_err} !== {8'h32, 1'b1}) $display("FAIL par_next got %h/%b exp 32/1", data, parity_err); else n_pass++;
    do_clear();
    n_checks++; if ({parity_err, irq, count} !== {2'b00, 4'd1}) $display("FAIL par_clear got perr=%b irq=%b cnt=%0d exp 0/0/1", parity_err, irq, count); else n_pass++;
    do_pop();
  endtask

  task automatic test_timeout();
    drive_bit(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)), 0, 0);
    cyc(TO + 50);
    m_ferr = 1; m_irq = 1;
    n_checks++; if ({frame_err, irq, count} !== {2'b11, 4'd0}) $display("FAIL timeout got ferr=%b irq=%b cnt=%0d exp 1/1/0", frame_err, irq, count); else n_pass++;
    send_frame(8'h5A, 1'b1, 1'b1, 0, 0);
    n_checks++; if ({data, count} !== {8'h5A, 4'd1}) $display("FAIL timeout_next got %h/%0d exp 5a/1", data, count); else n_pass++;
    do_pop(); do_clear();
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, good_par(b), 1'b1, 0, 0);
    end
    send_frame(8'hAA, 1'b1, 1'b1, 0, 0);
    n_checks++; if ({overflow, count, data} !== {m_ovf, 4'(q.size()), m_head()} || m_ovf !== 1'b1) $display("FAIL ovf_full got ovf=%b cnt=%0d head=%h exp 1/8/%h", overflow, count, data, m_head()); else n_pass++;
    do_clear();
    send_frame(8'hAA, 1'b1, 1'b1, 1, 0);
    n_checks++; if ({overflow, count} !== {1'b0, 4'd8}) $display("FAIL ovf_pop got ovf=%b cnt=%0d exp 0/8", overflow, count); else n_pass++;
    n_checks++; if (q[DEPTH-1] !== 8'hAA) $display("FAIL ovf_model_tail got %h exp aa", q[DEPTH-1]); else n_pass++;
    while (q.size() > 0) begin
      n_checks++; if (data !== q[0]) $display("FAIL ovf_drain got %h exp %h", data, q[0]); else n_pass++;
      do_pop();
    end
    do_clear();
  endtask

  task automatic test_glitch();
    send_frame(8'hC3, good_par(8'hC3), 1'b1, 0, 1);
    n_checks++; if ({data, count, parity_err, frame_err} !== {8'hC3, 4'd1, 2'b00}) $display("FAIL glitch got %h/%0d/%b%b exp c3/1/00", data, count, parity_err, frame_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive_bit(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 0, 0);
    rst_n = 0; #1;
    n_checks++; if ({data, valid, count, irq, parity_err, frame_err, overflow} !== 17'h0) $display("FAIL rst_mid got %h exp 0", {data, valid, count, irq, parity_err, frame_err, overflow}); else n_pass++;
    q.delete(); m_perr = 0; m_ferr = 0; m_ovf = 0; m_irq = 0;
    ps2_clk = 1; ps2_data = 1;
    cyc(3); rst_n = 1; cyc(3);
    send_frame(8'h29, good_par(8'h29), 1'b1, 0, 0);
    n_checks++; if ({data, count, frame_err} !== {8'h29, 4'd1, 1'b0}) $display("FAIL rst_next got %h/%0d/%b exp 29/1/0", data, count, frame_err); else n_pass++;
    do_pop(); do_clear();
  endtask

  task automatic test_random();
    logic [7:0] b;
    int kind;
    for (int it = 0; it < 16; it++) begin
      b    = 8'($urandom);
      kind = $urandom_range(0, 5);
      send_frame(b, (kind == 0) ? ~good_par(b) : good_par(b), (kind != 1), 0, 0);
      n_checks++;
      if ({data, valid, count} !== {m_head(), q.size() > 0, 4'(q.size())})
        $display("FAIL rand_fifo[%0d] got %h/%b/%0d exp %h/%0d", it, data, valid, count, m_head(), q.size());
      else n_pass++;
      n_checks++;
      if ({irq, parity_err, frame_err, overflow} !== {m_irq, m_perr, m_ferr, m_ovf})
        $display("FAIL rand_flags[%0d] got %b exp %b", it, {irq, parity_err, frame_err, overflow}, {m_irq, m_perr, m_ferr, m_ovf});
      else n_pass++;
      if ($urandom_range(0, 1)) do_pop();
      if ($urandom_range(0, 3) == 0) do_clear();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
